ciphertext_loader: RTL and testbench

- Upstream feeder for the bombe search block.
- Accepts a byte stream (ASCII ciphertext from the host/UART path) over a valid/ready handshake.
- Maps letters to 5-bit alphabet indices and stores up to MAX_LEN letters in an internal RAM.
- Once a complete message is held, the bombe reads it letter-by-letter through a random-access port with 1-cycle latency, then releases it so the next message can be loaded.

---
 rtl/bombe_pkg.sv | 37 +++
 rtl/message_ram.sv | 37 +++
 rtl/ciphertext_loader.sv | 143 ++++++++++++++
 tb/tb_ciphertext_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bombe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bombe_pkg
//  Description : Shared types, sizes and letter-mapping helpers for the
//                bombe front end (ciphertext loader and search block).
//  Revision    : 1.0 - initial release
// ============================================================================
package bombe_pkg;

  localparam int LETTER_W      = 5;
  localparam int ALPHABET_SIZE = 26;
  localparam int MAX_MSG_LEN   = 1024;
  localparam int MSG_ADDR_W    = 10;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } loader_state_t;

  // ASCII upper- or lower-case letter.
  function automatic logic is_letter(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  // Alphabet index 0..25; only meaningful when is_letter(b) holds.
  function automatic letter_t to_letter(input logic [7:0] b);
    if (b >= 8'h61) begin
      return letter_t'(b - 8'h61);
    end
    return letter_t'(b - 8'h41);
  endfunction

endpackage
`default_nettype wire

// File: rtl/message_ram.sv
`default_nettype none
// ============================================================================
//  Module      : message_ram
//  Description : Simple dual-port RAM, one write port and one registered
//                read port (read-first on same-address collision).
//                Ports: clk_i, we_i/waddr_i/wdata_i (write),
//                       raddr_i -> rdata_o (1-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module message_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset so the array and output register map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ciphertext_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ciphertext_loader
//  Description : Accepts an ASCII byte stream over valid/ready, stores the
//                letters (as 0..25) of one message in RAM, and holds it for
//                random-access reading by the bombe until released.
//  Ports       : clk_in, rst_in (async, active-high)
//                byte_valid_in/byte_in/byte_ready_out - upstream stream
//                rd_addr_in -> rd_data_out            - 1-cycle read port
//                msg_valid_out, msg_len_out, truncated_out - message status
//                msg_consumed_in                      - release pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ciphertext_loader
  import bombe_pkg::*;
#(
  parameter int         MAX_LEN   = MAX_MSG_LEN,
  parameter int         ADDR_W    = MSG_ADDR_W,
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              byte_valid_in,
  input  logic [7:0]        byte_in,
  output logic              byte_ready_out,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic [4:0]        rd_data_out,
  output logic              msg_valid_out,
  output logic [ADDR_W:0]   msg_len_out,
  output logic              truncated_out,
  input  logic              msg_consumed_in
);

  localparam logic [ADDR_W:0] c_last_len = (ADDR_W + 1)'(MAX_LEN - 1);

  loader_state_t   state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            trunc_q, trunc_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            rd_hit_q, rd_hit_d;

  logic            w_xfer;
  logic            w_is_letter;
  logic            w_is_term;
  logic            w_wr_en;
  letter_t         w_letter;
  letter_t         w_ram_rdata;

  assign w_xfer      = byte_valid_in && ready_q;
  assign w_is_letter = is_letter(byte_in);
  assign w_is_term   = !w_is_letter && (byte_in == TERM_CHAR);
  assign w_letter    = to_letter(byte_in);

  // State and registered outputs. Ready and valid are registered copies of
  // the next-state decode, so ready is low throughout reset and never
  // depends combinationally on byte_valid_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= LOAD;
      len_q    <= '0;
      trunc_q  <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      trunc_q  <= trunc_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      rd_hit_q <= rd_hit_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (w_xfer) begin
          if (w_is_letter) begin
            // The write filling the last slot moves straight to DRAIN.
            if (len_q == c_last_len) state_d = DRAIN;
          end else if (w_is_term && (len_q != '0)) begin
            state_d = HOLD;
          end
        end
      end
      DRAIN: begin
        if (w_xfer && w_is_term) state_d = HOLD;
      end
      HOLD: begin
        if (msg_consumed_in) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    w_wr_en  = (state_q == LOAD) && w_xfer && w_is_letter;
    len_d    = len_q;
    trunc_d  = trunc_q;
    if (w_wr_en) begin
      len_d = len_q + 1'b1;
    end
    if ((state_q == DRAIN) && w_xfer && w_is_letter) begin
      trunc_d = 1'b1;
    end
    if ((state_q == HOLD) && msg_consumed_in) begin
      len_d   = '0;
      trunc_d = 1'b0;
    end
    ready_d  = (state_d != HOLD);
    valid_d  = (state_d == HOLD);
    // Range test uses the length current when the address is sampled.
    rd_hit_d = ({1'b0, rd_addr_in} < len_q);
  end

  message_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W),
    .DATA_W (LETTER_W)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (w_wr_en),
    .waddr_i (len_q[ADDR_W-1:0]),
    .wdata_i (w_letter),
    .raddr_i (rd_addr_in),
    .rdata_o (w_ram_rdata)
  );

  // RAM output is unresettable; the registered hit flag forces zero for
  // out-of-range reads and during reset.
  assign rd_data_out    = rd_hit_q ? w_ram_rdata : '0;
  assign byte_ready_out = ready_q;
  assign msg_valid_out  = valid_q;
  assign msg_len_out    = len_q;
  assign truncated_out  = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_ciphertext_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ciphertext_loader
//  Description : Self-checking bench for ciphertext_loader, directed and
//                randomized byte streams against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ciphertext_loader;

  localparam int MAXL = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready;
  logic [9:0] rd_addr = 10'd0;
  logic [4:0] rd_data;
  logic       msg_valid;
  logic [10:0] msg_len;
  logic       truncated;
  logic       consumed = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: the message as a list of letters plus two flags.
  logic [4:0] m_msg[$];
  logic       m_hold  = 1'b0;
  logic       m_trunc = 1'b0;

  ciphertext_loader dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .byte_valid_in   (byte_valid),
    .byte_in         (byte_data),
    .byte_ready_out  (byte_ready),
    .rd_addr_in      (rd_addr),
    .rd_data_out     (rd_data),
    .msg_valid_out   (msg_valid),
    .msg_len_out     (msg_len),
    .truncated_out   (truncated),
    .msg_consumed_in (consumed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_msg.delete();
    m_hold  = 1'b0;
    m_trunc = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (b >= "A" && b <= "Z") begin
      if (m_msg.size() < MAXL) m_msg.push_back(5'(b - "A")); else m_trunc = 1'b1;
    end else if (b >= "a" && b <= "z") begin
      if (m_msg.size() < MAXL) m_msg.push_back(5'(b - "a")); else m_trunc = 1'b1;
    end else if (b == 8'h0A && m_msg.size() > 0) begin
      m_hold = 1'b1;
    end
  endtask

  // Offers one byte for one cycle; valid stays high across back-to-back calls.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    acc = byte_ready;
    @(posedge clk);
    if (acc) model_accept(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic read_check(input string tag, input int a);
    logic [4:0] exp;
    @(negedge clk);
    byte_valid = 1'b0;
    rd_addr = a[9:0];
    @(posedge clk);
    #1;
    exp = (a < m_msg.size()) ? m_msg[a] : 5'd0;
    check($sformatf("%s.rd[%0d]", tag, a), 32'(rd_data), 32'(exp));
  endtask

  // Called #1 after the edge that accepted the terminator.
  task automatic check_msg(input string tag);
    #1;
    check({tag, ".valid"}, 32'(msg_valid), 32'(m_hold));
    check({tag, ".len"},   32'(msg_len),   32'(m_msg.size()));
    check({tag, ".trunc"}, 32'(truncated), 32'(m_trunc));
    for (int a = 0; a < m_msg.size(); a++) read_check(tag, a);
    if (m_msg.size() < MAXL) read_check(tag, m_msg.size());
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    byte_valid = 1'b0;
    consumed = 1'b1;
    @(posedge clk);
    if (m_hold) model_clear();
    #1;
    check({tag, ".rel.valid"}, 32'(msg_valid),  32'(0));
    check({tag, ".rel.len"},   32'(msg_len),    32'(0));
    check({tag, ".rel.ready"}, 32'(byte_ready), 32'(1));
    @(negedge clk);
    consumed = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(byte_ready), 32'(0));
    check("rst.valid", 32'(msg_valid),  32'(0));
    check("rst.len",   32'(msg_len),    32'(0));
    check("rst.trunc", 32'(truncated),  32'(0));
    check("rst.rd",    32'(rd_data),    32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);

    // Basic message.
    send_str("HELLO\n");
    check_msg("hello");
    consume("hello");

    // Non-letters accepted but discarded.
    send_str("a B-c 9\n");
    check_msg("mixed");
    consume("mixed");

    // Empty lines suppressed.
    send_str("\n\n");
    #1;
    check("empty.valid", 32'(msg_valid),  32'(0));
    check("empty.ready", 32'(byte_ready), 32'(1));
    send_str("AB\n");
    check_msg("ab");
    consume("ab");

    // Overflow into the drain phase.
    for (int i = 0; i < MAXL; i++) send_byte("Z");
    #1;
    check("full.len",   32'(msg_len),    32'(MAXL));
    check("full.ready", 32'(byte_ready), 32'(1));
    for (int i = 0; i < 6; i++) send_byte("Z");
    #1;
    check("drain.ready", 32'(byte_ready), 32'(1));
    check("drain.trunc", 32'(truncated),  32'(1));
    send_byte(8'h0A);
    check_msg("full");

    // Held message refuses further bytes.
    for (int i = 0; i < 3; i++) begin
      send_byte("X");
      #1;
      check("hold.ready", 32'(byte_ready), 32'(0));
      check("hold.len",   32'(msg_len),    32'(MAXL));
    end
    consume("full");
    send_str("Q\n");
    check_msg("q");
    consume("q");

    // Release pulse outside HOLD has no effect.
    send_str("KL");
    @(negedge clk);
    byte_valid = 1'b0;
    consumed = 1'b1;
    @(negedge clk);
    consumed = 1'b0;
    check("ignrel.len", 32'(msg_len), 32'(2));
    send_byte(8'h0A);
    check_msg("kl");
    consume("kl");

    // Asynchronous reset mid-load.
    send_str("ABC");
    @(negedge clk);
    byte_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check("arst.len",   32'(msg_len),    32'(0));
    check("arst.valid", 32'(msg_valid),  32'(0));
    check("arst.ready", 32'(byte_ready), 32'(0));
    check("arst.rd",    32'(rd_data),    32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    send_str("D\n");
    check_msg("d");
    consume("d");

    // Randomized messages.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: b = 8'($urandom_range(8'h41, 8'h5A));
          1: b = 8'($urandom_range(8'h61, 8'h7A));
          2: b = 8'($urandom_range(0, 255));
          default: b = 8'h20;
        endcase
        if (b == 8'h0A) b = 8'h20;
        send_byte(b);
      end
      send_byte(8'h0A);
      check_msg($sformatf("rnd%0d", r));
      if (m_hold) consume($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
